// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit saturating counters and mispredict detection.
// Optional BP_STATS_EN adds saturating branch / mispredict counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [2:0]  update_branch,
    input  logic        actual_outcome,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_target,
    output logic        mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_tbl;
    logic [1:0]          ctr_tbl [ENTRIES];
    logic [TAG_BITS-1:0] tag_tbl [ENTRIES];
    logic [31:0]         tgt_tbl [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
    logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
    logic                  fetch_hit, upd_hit, upd;
    logic                  pc_unused;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[TAG_HI:TAG_LO];
    assign upd_idx   = update_pc[INDEX_BITS+1:2];
    assign upd_tag   = update_pc[TAG_HI:TAG_LO];
    assign pc_unused = ^{fetch_pc[31:TAG_HI+1], fetch_pc[1:0],
                         update_pc[31:TAG_HI+1], update_pc[1:0]};

    // Prediction reads the pre-edge table; writes become visible next cycle.
    assign fetch_hit   = valid_tbl[fetch_idx] && (tag_tbl[fetch_idx] == fetch_tag);
    assign pred_taken  = fetch_hit && ctr_tbl[fetch_idx][1];
    assign pred_target = pred_taken ? tgt_tbl[fetch_idx] : fetch_pc + 32'd4;

    assign upd        = update_en && (update_branch != 3'b000);
    assign upd_hit    = valid_tbl[upd_idx] && (tag_tbl[upd_idx] == upd_tag);
    assign mispredict = upd && ((update_pred_taken != actual_outcome) ||
                                (actual_outcome && (update_pred_target != update_target)));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_tbl <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_tbl[i] <= 2'b01;
        end else if (upd) begin
            if (upd_hit) begin
                ctr_tbl[upd_idx] <= ctr_step(ctr_tbl[upd_idx], actual_outcome);
            end else if (actual_outcome) begin
                valid_tbl[upd_idx] <= 1'b1;
                ctr_tbl[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target are meaningless while the entry is invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (upd && actual_outcome) begin
            tag_tbl[upd_idx] <= upd_tag;
            tgt_tbl[upd_idx] <= update_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (upd)
                branch_count <= sat_inc32(branch_count);
            if (mispredict)
                mispredict_count <= sat_inc32(mispredict_count);
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed plan followed by randomized traffic
// against a table model indexed/tagged with plain integer arithmetic.
module tb_branch_predictor;

    localparam int IB = 6;
    localparam int TB = 8;
    localparam int NE = 1 << IB;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic [2:0]  update_branch;
    logic        actual_outcome;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk),
        .reset(reset),
        .fetch_pc(fetch_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update_en(update_en),
        .update_pc(update_pc),
        .update_branch(update_branch),
        .actual_outcome(actual_outcome),
        .update_target(update_target),
        .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target),
        .mispredict(mispredict)
`ifdef BP_STATS_EN
        ,
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-slot state, counter kept as an integer strength 0..3.
    bit          m_valid [NE];
    int unsigned m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_ctr   [NE];
    longint      sb_branch = 0;
    longint      sb_misp   = 0;

    logic        obs_taken;
    logic        obs_misp;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % NE);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (IB + 2)) % (1 << TB);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        sb_branch = 0;
        sb_misp   = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit act, input logic [31:0] tgt);
        int i;
        i = slot(pc);
        if (m_hit(pc)) begin
            if (act) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (act) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit chk, input logic [31:0] fpc,
                        input bit en, input logic [31:0] upc, input logic [2:0] br,
                        input bit act, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt);
        bit u;
        bit e_mp;
        reset              = rst;
        fetch_pc           = fpc;
        update_en          = en;
        update_pc          = upc;
        update_branch      = br;
        actual_outcome     = act;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
        #1;
        u    = en && (br != 3'd0);
        e_mp = u && ((ptk != act) || (act && (ptgt != tgt)));
        obs_taken = pred_taken;
        obs_misp  = mispredict;
        if (chk) begin
            check("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(fpc)});
            check("pred_target", pred_target, m_pred_tgt(fpc));
            check("mispredict", {31'd0, mispredict}, {31'd0, e_mp});
`ifdef BP_STATS_EN
            check("branch_count", branch_count, sb_branch[31:0]);
            check("mispredict_count", mispredict_count, sb_misp[31:0]);
`endif
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (u) begin
                model_update(upc, act, tgt);
                if (sb_branch < 64'hFFFF_FFFF) sb_branch++;
            end
            if (e_mp && sb_misp < 64'hFFFF_FFFF) sb_misp++;
        end
        @(negedge clk);
    endtask

    task automatic probe(input string tag, input logic [31:0] fpc,
                         input bit exp_taken, input logic [31:0] exp_tgt);
        step(1'b0, 1'b1, fpc, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        check({tag, "_taken"}, {31'd0, obs_taken}, {31'd0, exp_taken});
    endtask

    logic [31:0] pool [8];

    initial begin
        logic [31:0] fpc, upc, tgt, ptgt;
        bit          en, act, ptk, rst;
        logic [2:0]  br;
        pool = '{32'h100, 32'h200, 32'h600, 32'h104, 32'h1100, 32'h3fc, 32'h40, 32'hffff_fffc};

        // Reset, then a reset coinciding with an update must leave no trace.
        step(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 3'd1, 1'b1, 32'h999, 1'b0, 32'h0);
        probe("reset", 32'h40, 1'b0, 32'h44);
        check("reset_target", pred_target, 32'h44);

        // Allocate and predict.
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h104);
        check("alloc_misp", {31'd0, obs_misp}, 32'd1);
        probe("alloc", 32'h100, 1'b1, 32'h200);
        check("alloc_target", pred_target, 32'h200);

        // Saturation and hysteresis.
        repeat (3) step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 3'd2, 1'b1, 32'h200, 1'b1, 32'h200);
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 3'd2, 1'b0, 32'h200, 1'b1, 32'h200);
        probe("hyst1", 32'h100, 1'b1, 32'h200);
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 3'd2, 1'b0, 32'h200, 1'b1, 32'h200);
        probe("hyst2", 32'h100, 1'b0, 32'h104);
        check("hyst2_target", pred_target, 32'h104);

        // Alias eviction: 0x200 shares slot 0 with 0x100.
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h104);
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h100 + (32'd1 << (IB + 2)), 3'd1, 1'b1, 32'h300, 1'b0, 32'h204);
        probe("evicted", 32'h100, 1'b0, 32'h104);
        probe("alias", 32'h200, 1'b1, 32'h300);
        check("alias_target", pred_target, 32'h300);

        // Non-branch and not-taken miss.
        step(1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 3'd0, 1'b0, 32'h0, 1'b1, 32'h0);
        check("nonbranch_misp", {31'd0, obs_misp}, 32'd0);
        probe("nonbranch", 32'h200, 1'b1, 32'h300);
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'h500, 3'd3, 1'b0, 32'h0, 1'b0, 32'h504);
        probe("nt_miss", 32'h500, 1'b0, 32'h504);

        // Same-cycle read and write.
        step(1'b0, 1'b1, 32'h600, 1'b1, 32'h600, 3'd1, 1'b1, 32'h700, 1'b0, 32'h604);
        check("same_cycle_old", {31'd0, obs_taken}, 32'd0);
        probe("same_cycle_new", 32'h600, 1'b1, 32'h700);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            fpc  = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
            upc  = ($urandom_range(0, 5) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
            en   = ($urandom_range(0, 4) != 0);
            br   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            act  = $urandom_range(0, 1) == 1;
            tgt  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : ($urandom() & 32'hffff_fffc);
            ptk  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1) : m_pred(upc);
            ptgt = ($urandom_range(0, 3) == 0) ? tgt : m_pred_tgt(upc);
            rst  = ($urandom_range(0, 63) == 0);
            step(rst, 1'b1, fpc, en, upc, br, act, tgt, ptk, ptgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
